// File: rtl/addsub_serial_ctrl.sv
// Nibble-serial A+B / A-B sequencer: one 4-bit slice per cycle, LSB first, carry registered.
// Optional `ADDSUB_FLAGS_EN adds registered o_zero / o_neg result flags.
module addsub_serial_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_a,
  input  logic [4*NIBBLES-1:0] i_b,
  input  logic                 i_mode,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [4*NIBBLES-1:0] o_result,
  output logic                 o_c,
  output logic                 o_ovf
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic                 o_zero,
  output logic                 o_neg
`endif
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, shadow_q, result_q;
  logic            mode_q, carry_q, busy_q, done_q, c_q, ovf_q;
  logic [IdxW-1:0] idx_q;
`ifdef ADDSUB_FLAGS_EN
  logic            zero_q, neg_q;
`endif

  logic [3:0]   a_n, b_n;
  logic [4:0]   sum5;
  logic         c_msb_in;
  logic [W-1:0] shadow_d;

  always_comb begin
    a_n      = a_q[{idx_q, 2'b00} +: 4];
    b_n      = b_q[{idx_q, 2'b00} +: 4] ^ {4{mode_q}};
    sum5     = {1'b0, a_n} + {1'b0, b_n} + {4'b0000, carry_q};
    // Carry into bit 3 recovered from the sum bit: s3 = a3 ^ b3 ^ c3.
    c_msb_in = a_n[3] ^ b_n[3] ^ sum5[3];
    shadow_d = shadow_q;
    shadow_d[{idx_q, 2'b00} +: 4] = sum5[3:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_q      <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
`ifdef ADDSUB_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= i_b;
            mode_q  <= i_mode;
            carry_q <= i_mode;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          shadow_q <= shadow_d;
          carry_q  <= sum5[4];
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            idx_q    <= '0;
            result_q <= shadow_d;
            c_q      <= sum5[4];
            ovf_q    <= c_msb_in ^ sum5[4];
`ifdef ADDSUB_FLAGS_EN
            zero_q   <= (shadow_d == '0);
            neg_q    <= shadow_d[W-1];
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_c      = c_q;
  assign o_ovf    = ovf_q;
`ifdef ADDSUB_FLAGS_EN
  assign o_zero   = zero_q;
  assign o_neg    = neg_q;
`endif

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Directed bench for addsub_serial_ctrl (NIBBLES=4), hand-computed expectations.
module tb_addsub_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        mode;
  logic        busy, done, c, ovf;
  logic [15:0] res;
`ifdef ADDSUB_FLAGS_EN
  logic        zero, neg;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_serial_ctrl #(.NIBBLES(4)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .i_mode   (mode),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (res),
    .o_c      (c),
    .o_ovf    (ovf)
`ifdef ADDSUB_FLAGS_EN
    ,
    .o_zero   (zero),
    .o_neg    (neg)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for one edge; returns in cycle 1 of the op.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tm);
    a = ta; b = tb; mode = tm; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (res !== 16'h0000) begin n_err++; $display("FAIL reset_result got %h want 0000", res); end
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL reset_c got %b want 0", c); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++; if ({zero, neg} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {zero, neg}); end
`endif
    tick();
  endtask

  task automatic test_add();
    start_op(16'h1234, 16'h0FFF, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; mode = 1'b1;  // must not disturb the captured op
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy cyc%0d got %b want 1", k, busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_early cyc%0d got %b want 0", k, done); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL add_done cyc5 got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_busy_cyc5 got %b want 0", busy); end
    n_cmp++; if (res !== 16'h2233) begin n_err++; $display("FAIL add_result got %h want 2233", res); end
    n_cmp++; if ({c, ovf} !== 2'b00) begin n_err++; $display("FAIL add_c_ovf got %b want 00", {c, ovf}); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse got %b want 0", done); end
    n_cmp++; if (res !== 16'h2233) begin n_err++; $display("FAIL add_hold got %h want 2233", res); end
    tick();
  endtask

  task automatic test_sub_borrow();
    start_op(16'h0005, 16'h0007, 1'b1);
    repeat (4) tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL sub_done got %b want 1", done); end
    n_cmp++; if (res !== 16'hFFFE) begin n_err++; $display("FAIL sub_result got %h want fffe", res); end
    n_cmp++; if ({c, ovf} !== 2'b00) begin n_err++; $display("FAIL sub_c_ovf got %b want 00", {c, ovf}); end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++; if ({zero, neg} !== 2'b01) begin n_err++; $display("FAIL sub_flags got %b want 01", {zero, neg}); end
`endif
    tick();
  endtask

  task automatic test_overflow();
    start_op(16'h7FFF, 16'h0001, 1'b0);
    repeat (4) tick();
    n_cmp++; if (res !== 16'h8000) begin n_err++; $display("FAIL ovf_add_result got %h want 8000", res); end
    n_cmp++; if ({c, ovf} !== 2'b01) begin n_err++; $display("FAIL ovf_add_c_ovf got %b want 01", {c, ovf}); end
    tick();
    start_op(16'h8000, 16'h0001, 1'b1);
    repeat (4) tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ovf_sub_done got %b want 1", done); end
    n_cmp++; if (res !== 16'h7FFF) begin n_err++; $display("FAIL ovf_sub_result got %h want 7fff", res); end
    n_cmp++; if ({c, ovf} !== 2'b11) begin n_err++; $display("FAIL ovf_sub_c_ovf got %b want 11", {c, ovf}); end
    tick();
  endtask

  task automatic test_reset_mid();
    start_op(16'h1111, 16'h2222, 1'b0);
    tick();                       // cycle 2
    rst = 1'b1;
    tick();                       // cycle 3, reset taken at the edge
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (res !== 16'h0000) begin n_err++; $display("FAIL rstmid_result got %h want 0000", res); end
    n_cmp++; if ({c, ovf} !== 2'b00) begin n_err++; $display("FAIL rstmid_c_ovf got %b want 00", {c, ovf}); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done cyc%0d got %b want 0", k, done); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    start_op(16'h00FF, 16'h00FF, 1'b1);
    repeat (4) tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done1 got %b want 1", done); end
    n_cmp++; if (res !== 16'h0000) begin n_err++; $display("FAIL b2b_result1 got %h want 0000", res); end
    n_cmp++; if ({c, ovf} !== 2'b10) begin n_err++; $display("FAIL b2b_c_ovf1 got %b want 10", {c, ovf}); end
`ifdef ADDSUB_FLAGS_EN
    n_cmp++; if ({zero, neg} !== 2'b10) begin n_err++; $display("FAIL b2b_flags1 got %b want 10", {zero, neg}); end
`endif
    start_op(16'h0001, 16'h0001, 1'b0);   // issued during the DONE cycle
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy cyc%0d got %b want 1", k, busy); end
      n_cmp++; if (res !== 16'h0000) begin n_err++; $display("FAIL b2b_hold cyc%0d got %h want 0000", k, res); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done2 got %b want 1", done); end
    n_cmp++; if (res !== 16'h0002) begin n_err++; $display("FAIL b2b_result2 got %h want 0002", res); end
    n_cmp++; if ({c, ovf} !== 2'b00) begin n_err++; $display("FAIL b2b_c_ovf2 got %b want 00", {c, ovf}); end
    tick();
  endtask

  task automatic test_start_busy();
    start_op(16'h0101, 16'h0202, 1'b0);
    tick();                       // cycle 2
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();                       // cycle 3
    start = 1'b0;
    tick();                       // cycle 4
    tick();                       // cycle 5
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL busy_start_done got %b want 1", done); end
    n_cmp++; if (res !== 16'h0303) begin n_err++; $display("FAIL busy_start_result got %h want 0303", res); end
    for (int k = 6; k <= 12; k++) begin
      tick();
      n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL busy_start_extra cyc%0d done,busy got %b want 00", k, {done, busy}); end
    end
    n_cmp++; if (res !== 16'h0303) begin n_err++; $display("FAIL busy_start_hold got %h want 0303", res); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0;
    test_reset();
    test_add();
    test_sub_borrow();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_serial_ctrl.md
Name: addsub_serial_ctrl

Overview:
- Multi-nibble add/subtract sequencer. Computes a full-width A±B on one shared 4-bit add/sub nibble slice, LSB nibble first, over NIBBLES cycles.
- The carry is registered between nibbles.
- Sits between the control logic and the 4-bit arithmetic datapath, so wide operands need no wide adder.
- Start/done handshake; result and flags are held until the next operation completes.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- i_clk  input  1  rising-edge clock
- i_reset  input  1  synchronous active-high reset
- i_start  input  1  start request; sampled only while o_busy=0
- i_a  input  W  operand A; captured on accepted start
- i_b  input  W  operand B; captured on accepted start
- i_mode  input  1  0 = A+B, 1 = A−B; captured on accepted start
- o_busy  output  1  high while in RUN
- o_done  output  1  one-cycle pulse when a result is published
- o_result  output  W  registered result
- o_c  output  1  final carry out; on subtract, 1 = no borrow (A ≥ B unsigned)
- o_ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - state=IDLE.
  - o_busy=0, o_done=0, o_result=0, o_c=0, o_ovf=0.
  - Internal operand, carry and index registers cleared.
  - Reset has priority over everything, including mid-RUN; a partial result is discarded and o_done is never pulsed for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - i_start=1 → latch i_a, i_b, i_mode; carry←i_mode; idx←0; go to RUN.
  - Otherwise stay.
- RUN (o_busy=1), once per cycle:
  - Slice operation: a_n=A[4idx+3:4idx], b_n=B[4idx+3:4idx] XOR {4{mode}}. {cout,s_n} = a_n + b_n + carry, 5-bit sum.
  - Write s_n into the shadow result nibble idx; carry←cout; idx←idx+1.
  - At idx=NIBBLES-1: also record the carry into bit 3 of this slice as c_msb_in, then go to DONE.
  - i_start is ignored throughout RUN.
- Transition into DONE:
  - o_result←shadow result.
  - o_c←final cout.
  - o_ovf←c_msb_in XOR final cout.
- DONE (o_busy=0, o_done=1 for exactly this cycle):
  - i_start=1 → accept a new operation exactly as in IDLE and go to RUN. This gives back-to-back operation with no idle cycle.
  - Otherwise go to IDLE.
- Latency: i_start accepted in cycle 0 → o_done=1 in cycle NIBBLES+1. Throughput is one op per NIBBLES+1 cycles.
- Output hold: o_result, o_c and o_ovf are stable from the o_done cycle until the next o_done or reset. They are unaffected by operand changes or by an operation in progress.
- Width rules: all arithmetic is modulo 2^W. Carry-in to slice 0 = mode, giving the two's-complement subtract.
- Captured operands: input changes after acceptance have no effect on the running operation.

Optional Feature:
- Macro: ADDSUB_FLAGS_EN.
- Defined:
  - Adds output ports o_zero (1) and o_neg (1).
  - Both are registered at the transition into DONE: o_zero = (result==0), o_neg = result[W-1].
  - Both reset to 0 and are held like o_result.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan (NIBBLES=4):
- Add: A=0x1234, B=0x0FFF, mode=0 → o_result=0x2233, o_c=0, o_ovf=0, o_done exactly in cycle 5 after start, o_busy high in cycles 1–4.
- Subtract with borrow: A=0x0005, B=0x0007, mode=1 → 0xFFFE, o_c=0, o_ovf=0; with flags, o_neg=1, o_zero=0.
- Signed overflow: A=0x7FFF+B=0x0001, mode=0 → 0x8000, o_c=0, o_ovf=1. Then A=0x8000−B=0x0001, mode=1 → 0x7FFF, o_c=1, o_ovf=1.
- Zero and back-to-back:
  - A=0x00FF−B=0x00FF → 0x0000, o_c=1; with flags, o_zero=1.
  - i_start held high in the DONE cycle with A=0x0001+B=0x0001 → second o_done 5 cycles later with 0x0002.
- Start while busy: second i_start (A=0xFFFF, B=0xFFFF) pulsed in RUN cycle 2 → ignored; the first op's result is published and no extra o_done occurs.
- Reset mid-op: i_reset in RUN cycle 2 → next cycle o_busy=0, o_result=0, o_c=0, o_ovf=0, and no o_done until a new start.
